// File: rtl/matbi_watch_pkg.sv
// Shared widths, moduli and FSM encoding for the time-of-day counter.
package matbi_watch_pkg;
  localparam int HOUR_W  = 5;
  localparam int MIN_W   = 6;
  localparam int SEC_W   = 6;
  localparam int SEC_MOD = 60;
  localparam int MIN_MOD = 60;

  typedef enum logic [1:0] {
    S_STOP = 2'd0,
    S_RUN  = 2'd1,
    S_LOAD = 2'd2
  } state_t;
endpackage

// File: rtl/matbi_mod_cnt.sv
// Modulo-N counter stage with synchronous load; carry is combinational so stages chain in one cycle.
module matbi_mod_cnt #(
  parameter int N = 60,
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         carry
);
  localparam logic [W-1:0] LAST = W'(N - 1);

  assign carry = inc & (value == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      value <= (value == LAST) ? '0 : value + 1'b1;
    end
  end
endmodule

// File: rtl/matbi_watch_time_cnt.sv
// Time-of-day counter: consumes one-second ticks, accepts time sets via valid/ready,
// and emits registered minute/hour/day rollover pulses.
//
//   state  | meaning
//   S_STOP | ticks ignored, set requests accepted
//   S_RUN  | ticks advance time, set requests accepted
//   S_LOAD | one cycle: validate staged time, commit or flag error
module matbi_watch_time_cnt
  import matbi_watch_pkg::*;
#(
  parameter int P_HOUR_MAX = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_run_en,
  input  logic              i_one_sec_tick,
  input  logic              i_set_valid,
  output logic              o_set_ready,
  input  logic [HOUR_W-1:0] i_set_hour,
  input  logic [MIN_W-1:0]  i_set_min,
  input  logic [SEC_W-1:0]  i_set_sec,
  output logic              o_set_err,
  output logic [HOUR_W-1:0] o_hour,
  output logic [MIN_W-1:0]  o_min,
  output logic [SEC_W-1:0]  o_sec,
  output logic              o_min_tick,
  output logic              o_hour_tick,
  output logic              o_day_tick
);
  state_t            state, state_nx;
  logic              rdy_q;
  logic              pend, pend_nx;
  logic [HOUR_W-1:0] stg_hour;
  logic [MIN_W-1:0]  stg_min;
  logic [SEC_W-1:0]  stg_sec;
  logic              hs, set_ok, commit, sec_inc;
  logic              sec_carry, min_carry, hour_carry;

  // rdy_q keeps ready low through reset and sets on the first clock after release
  assign o_set_ready = rdy_q & (state != S_LOAD);
  assign hs          = i_set_valid & o_set_ready;
  assign set_ok      = (stg_hour < HOUR_W'(P_HOUR_MAX)) &&
                       (stg_min  <= MIN_W'(MIN_MOD - 1)) &&
                       (stg_sec  <= SEC_W'(SEC_MOD - 1));
  assign commit      = (state == S_LOAD) & set_ok;
  assign sec_inc     = (state == S_RUN) & ~hs & ((i_one_sec_tick & i_run_en) | pend);

  always_comb begin
    state_nx = state;
    pend_nx  = 1'b0;
    case (state)
      S_STOP: begin
        if (hs) begin
          state_nx = S_LOAD;
          pend_nx  = pend | i_one_sec_tick;
        end else if (i_run_en) begin
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (hs) begin
          state_nx = S_LOAD;
          pend_nx  = pend | i_one_sec_tick;
        end else if (!i_run_en) begin
          state_nx = S_STOP;
        end
      end
      S_LOAD: begin
        // a pending tick only survives if we resume counting
        state_nx = i_run_en ? S_RUN : S_STOP;
        pend_nx  = i_run_en & (pend | i_one_sec_tick);
      end
      default: state_nx = S_STOP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_STOP;
      rdy_q       <= 1'b0;
      pend        <= 1'b0;
      stg_hour    <= '0;
      stg_min     <= '0;
      stg_sec     <= '0;
      o_set_err   <= 1'b0;
      o_min_tick  <= 1'b0;
      o_hour_tick <= 1'b0;
      o_day_tick  <= 1'b0;
    end else begin
      state       <= state_nx;
      rdy_q       <= 1'b1;
      pend        <= pend_nx;
      o_set_err   <= (state == S_LOAD) & ~set_ok;
      o_min_tick  <= sec_carry;
      o_hour_tick <= min_carry;
      o_day_tick  <= hour_carry;
      if (hs) begin
        stg_hour <= i_set_hour;
        stg_min  <= i_set_min;
        stg_sec  <= i_set_sec;
      end
    end
  end

  matbi_mod_cnt #(.N(SEC_MOD), .W(SEC_W)) u_sec (
    .clk(clk), .reset(reset), .inc(sec_inc), .load(commit),
    .load_val(stg_sec), .value(o_sec), .carry(sec_carry)
  );

  matbi_mod_cnt #(.N(MIN_MOD), .W(MIN_W)) u_min (
    .clk(clk), .reset(reset), .inc(sec_carry), .load(commit),
    .load_val(stg_min), .value(o_min), .carry(min_carry)
  );

  matbi_mod_cnt #(.N(P_HOUR_MAX), .W(HOUR_W)) u_hour (
    .clk(clk), .reset(reset), .inc(min_carry), .load(commit),
    .load_val(stg_hour), .value(o_hour), .carry(hour_carry)
  );
endmodule

// File: tb/tb_matbi_watch_time_cnt.sv
// Directed bench for the time-of-day counter; a 24 h and a 12 h instance share stimulus.
module tb_matbi_watch_time_cnt;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run_en = 1'b0;
  logic       tick = 1'b0;
  logic       set_valid = 1'b0;
  logic [4:0] set_hour = '0;
  logic [5:0] set_min = '0;
  logic [5:0] set_sec = '0;

  logic       ready, err, mt, ht, dt;
  logic [4:0] hour;
  logic [5:0] min, sec;
  logic       ready12, err12, mt12, ht12, dt12;
  logic [4:0] hour12;
  logic [5:0] min12, sec12;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matbi_watch_time_cnt #(.P_HOUR_MAX(24)) u_dut (
    .clk(clk), .reset(reset), .i_run_en(run_en), .i_one_sec_tick(tick),
    .i_set_valid(set_valid), .o_set_ready(ready), .i_set_hour(set_hour),
    .i_set_min(set_min), .i_set_sec(set_sec), .o_set_err(err),
    .o_hour(hour), .o_min(min), .o_sec(sec),
    .o_min_tick(mt), .o_hour_tick(ht), .o_day_tick(dt)
  );

  matbi_watch_time_cnt #(.P_HOUR_MAX(12)) u_dut12 (
    .clk(clk), .reset(reset), .i_run_en(run_en), .i_one_sec_tick(tick),
    .i_set_valid(set_valid), .o_set_ready(ready12), .i_set_hour(set_hour),
    .i_set_min(set_min), .i_set_sec(set_sec), .o_set_err(err12),
    .o_hour(hour12), .o_min(min12), .o_sec(sec12),
    .o_min_tick(mt12), .o_hour_tick(ht12), .o_day_tick(dt12)
  );

  wire [16:0] t24 = {hour, min, sec};
  wire [16:0] t12 = {hour12, min12, sec12};
  wire [5:0]  outs24 = {ready, err, mt, ht, dt, 1'b0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({t24, err, mt, ht, dt, ready} !== 22'd0) begin
      errors++; $display("FAIL reset_outputs got=%h want=0", {t24, err, mt, ht, dt, ready});
    end
    step();
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready_held got=%b want=0", ready); end
    reset = 1'b1;
    step();
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got=%b want=1", ready); end
  endtask

  task automatic test_count_minute();
    int mt_cnt = 0;
    int mt_at = 0;
    run_en = 1'b1;
    step();
    for (int i = 1; i <= 60; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      if (mt === 1'b1) begin mt_cnt++; mt_at = i; end
      if (i == 30) begin
        checks++;
        if (t24 !== {5'd0, 6'd0, 6'd30}) begin
          errors++; $display("FAIL count_30 got=%h want=%h", t24, {5'd0, 6'd0, 6'd30});
        end
      end
      for (int k = 0; k < 4; k++) begin
        step();
        if (mt === 1'b1) begin mt_cnt++; mt_at = 100 + i; end
      end
    end
    checks++;
    if (t24 !== {5'd0, 6'd1, 6'd0}) begin
      errors++; $display("FAIL count_60 got=%h want=%h", t24, {5'd0, 6'd1, 6'd0});
    end
    checks++;
    if (mt_cnt !== 1 || mt_at !== 60) begin
      errors++; $display("FAIL min_tick_once got cnt=%0d at=%0d want cnt=1 at=60", mt_cnt, mt_at);
    end
  endtask

  task automatic test_day_rollover();
    set_hour = 5'd23; set_min = 6'd59; set_sec = 6'd58; set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    step();
    checks++;
    if (t24 !== {5'd23, 6'd59, 6'd58}) begin
      errors++; $display("FAIL set_235958 got=%h want=%h", t24, {5'd23, 6'd59, 6'd58});
    end
    tick = 1'b1; step(); tick = 1'b0;
    checks++;
    if ({t24, mt, ht, dt} !== {5'd23, 6'd59, 6'd59, 3'b000}) begin
      errors++; $display("FAIL tick_235959 got=%h want=%h", {t24, mt, ht, dt}, {5'd23, 6'd59, 6'd59, 3'b000});
    end
    tick = 1'b1; step(); tick = 1'b0;
    checks++;
    if ({t24, mt, ht, dt} !== {17'd0, 3'b111}) begin
      errors++; $display("FAIL day_wrap got=%h want=%h", {t24, mt, ht, dt}, {17'd0, 3'b111});
    end
    step();
    checks++;
    if ({mt, ht, dt} !== 3'b000) begin
      errors++; $display("FAIL pulses_one_cycle got=%b want=000", {mt, ht, dt});
    end
  endtask

  task automatic test_set_error();
    set_hour = 5'd24; set_min = 6'd10; set_sec = 6'd0; set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    checks++;
    if ({ready, err} !== 2'b00) begin
      errors++; $display("FAIL err_n1 got ready,err=%b want=00", {ready, err});
    end
    step();
    checks++;
    if ({ready, err, t24} !== {2'b11, 17'd0}) begin
      errors++; $display("FAIL err_n2 got=%h want=%h", {ready, err, t24}, {2'b11, 17'd0});
    end
    step();
    checks++;
    if ({ready, err} !== 2'b10) begin
      errors++; $display("FAIL err_n3 got ready,err=%b want=10", {ready, err});
    end
  endtask

  task automatic test_pending_tick();
    set_hour = 5'd10; set_min = 6'd20; set_sec = 6'd30; set_valid = 1'b1; tick = 1'b1;
    step();
    set_valid = 1'b0;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL pend_load_ready got=%b want=0", ready); end
    step();
    tick = 1'b0;
    checks++;
    if (t24 !== {5'd10, 6'd20, 6'd30}) begin
      errors++; $display("FAIL pend_n2 got=%h want=%h", t24, {5'd10, 6'd20, 6'd30});
    end
    step();
    checks++;
    if (t24 !== {5'd10, 6'd20, 6'd31}) begin
      errors++; $display("FAIL pend_n3 got=%h want=%h", t24, {5'd10, 6'd20, 6'd31});
    end
    step(); step();
    checks++;
    if (t24 !== {5'd10, 6'd20, 6'd31}) begin
      errors++; $display("FAIL pend_once got=%h want=%h", t24, {5'd10, 6'd20, 6'd31});
    end
  endtask

  task automatic test_freeze();
    run_en = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      tick = 1'b1; step(); tick = 1'b0; step();
    end
    checks++;
    if (t24 !== {5'd10, 6'd20, 6'd31}) begin
      errors++; $display("FAIL freeze got=%h want=%h", t24, {5'd10, 6'd20, 6'd31});
    end
  endtask

  task automatic test_hour12();
    run_en = 1'b1;
    set_hour = 5'd11; set_min = 6'd59; set_sec = 6'd59; set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    step();
    checks++;
    if (t12 !== {5'd11, 6'd59, 6'd59}) begin
      errors++; $display("FAIL h12_set got=%h want=%h", t12, {5'd11, 6'd59, 6'd59});
    end
    tick = 1'b1; step(); tick = 1'b0;
    checks++;
    if ({t12, dt12} !== {17'd0, 1'b1}) begin
      errors++; $display("FAIL h12_wrap got=%h want=%h", {t12, dt12}, {17'd0, 1'b1});
    end
    checks++;
    if ({t24, dt} !== {5'd12, 6'd0, 6'd0, 1'b0}) begin
      errors++; $display("FAIL h24_noon got=%h want=%h", {t24, dt}, {5'd12, 6'd0, 6'd0, 1'b0});
    end
  endtask

  task automatic test_reset_in_load();
    set_hour = 5'd5; set_min = 6'd6; set_sec = 6'd7; set_valid = 1'b1; tick = 1'b1;
    step();
    set_valid = 1'b0; tick = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if ({t24, err, mt, ht, dt, ready} !== 22'd0) begin
      errors++; $display("FAIL rst_load_async got=%h want=0", {t24, err, mt, ht, dt, ready});
    end
    #1;
    reset = 1'b1;
    step();
    checks++;
    if ({ready, t24} !== {1'b1, 17'd0}) begin
      errors++; $display("FAIL rst_load_release got=%h want=%h", {ready, t24}, {1'b1, 17'd0});
    end
    tick = 1'b1; step(); tick = 1'b0;
    step(); step();
    checks++;
    if (t24 !== {5'd0, 6'd0, 6'd1}) begin
      errors++; $display("FAIL rst_load_tick got=%h want=%h", t24, {5'd0, 6'd0, 6'd1});
    end
  endtask

  initial begin
    test_reset();
    test_count_minute();
    test_day_rollover();
    test_set_error();
    test_pending_tick();
    test_freeze();
    test_hour12();
    test_reset_in_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/matbi_watch_time_cnt.md
# matbi_watch_time_cnt

Time-of-day counter that consumes the one-second tick stream and maintains hours, minutes and seconds. It is the tick consumer at the far end of the tick generator and sits between that generator and the display and alarm logic. Time is loaded through a valid/ready set handshake. Minute, hour and day rollover pulses are produced for downstream blocks.

## Interface
Parameters:
- P_HOUR_MAX, 24: hour modulus; 12 or 24 only. Hour range is 0..P_HOUR_MAX-1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- i_run_en  in  1  count enable; ticks are ignored while low.
- i_one_sec_tick  in  1  single-cycle tick pulse from the tick generator.
- i_set_valid  in  1  set request; held until accepted.
- o_set_ready  out  1  block can accept a set request.
- i_set_hour  in  5  requested hour.
- i_set_min  in  6  requested minute.
- i_set_sec  in  6  requested second.
- o_set_err  out  1  1-cycle pulse when a set request is rejected.
- o_hour  out  5  current hour.
- o_min  out  6  current minute.
- o_sec  out  6  current second.
- o_min_tick  out  1  1-cycle pulse on seconds wrap 59->0.
- o_hour_tick  out  1  1-cycle pulse on minutes wrap 59->0.
- o_day_tick  out  1  1-cycle pulse on hours wrap (P_HOUR_MAX-1)->0.

## Operation
- FSM states: S_STOP, S_RUN, S_LOAD. Reset state is S_STOP.
- S_STOP -> S_RUN when i_run_en=1. S_RUN -> S_STOP when i_run_en=0.
- From S_STOP or S_RUN, a handshake (i_set_valid & o_set_ready) latches the set fields into staging registers and moves to S_LOAD.
- S_LOAD lasts exactly 1 cycle:
  - Validate: hour < P_HOUR_MAX, min <= 59, sec <= 59.
  - If valid, commit all three fields and clear the prescaler-free carry chain.
  - If invalid, leave time unchanged and pulse o_set_err.
  - Then go to S_RUN if i_run_en=1, else S_STOP.
- o_set_ready = 1 in S_STOP and S_RUN; 0 in S_LOAD and during reset.
- Counting happens only in S_RUN with i_one_sec_tick=1:
  - sec increments.
  - On sec 59: sec goes to 0, min increments, o_min_tick fires.
  - On min 59 with carry: min goes to 0, hour increments, o_hour_tick fires.
  - On hour P_HOUR_MAX-1 with carry: hour goes to 0, o_day_tick fires.
- Tick in the handshake cycle: set a one-deep pending flag; do not increment. Tick during S_LOAD: set the same flag. A second tick while the flag is set is dropped.
- Pending flag behaviour:
  - Consumed on the first S_RUN cycle after S_LOAD, incrementing the committed (or unchanged) time exactly once.
  - Cleared without effect if S_LOAD exits to S_STOP.
- Width rule: all compares are unsigned at field width. Counter fields never hold out-of-range values.

## Timing
- Reset value of every output: o_hour=0, o_min=0, o_sec=0, all tick pulses 0, o_set_err=0, o_set_ready=0 while reset is asserted.
- o_set_ready goes to 1 on the first clk after reset deasserts.
- Tick latency: tick at cycle N updates the time at N+1. Rollover pulses are registered and coincide with the updated value at N+1.
- Set handshake at cycle N:
  - S_LOAD at N+1.
  - New time (or o_set_err) visible at N+2.
  - o_set_ready low for exactly cycle N+1.
  - Pending tick applied at N+2 -> visible at N+3.
- Reset mid-S_LOAD: the commit is aborted, time is 0, and the pending flag is cleared.
- Back-to-back set requests are accepted at most every 2 cycles.

## Structure
- Package matbi_watch_pkg holds:
  - field widths: HOUR_W=5, MIN_W=6, SEC_W=6;
  - constant SEC_MOD = MIN_MOD = 60;
  - FSM state typedef/encoding.
- Sub-module matbi_mod_cnt: parameterised modulo-N counter with inputs inc, load and load_val, and outputs value and carry (carry = inc & value==N-1). It is instantiated three times as a chain: sec carry drives min inc, min carry drives hour inc. The FSM, validation, pending flag and pulse registers live in the top.

## Test plan
- Reset, run_en=1, 60 ticks spaced 5 cycles apart -> 00:01:00; o_min_tick high exactly once, one cycle after tick 60.
- Set 23:59:58 (P_HOUR_MAX=24), then 2 ticks -> 23:59:59, then 00:00:00; on the second tick o_min_tick, o_hour_tick and o_day_tick are high in the same cycle.
- Set hour=24, min=10, sec=0 -> o_set_err pulses at N+2; time unchanged; o_set_ready low only at N+1.
- Set 10:20:30 with a tick in the handshake cycle and another in S_LOAD -> 10:20:30 at N+2, 10:20:31 at N+3, never 10:20:32.
- run_en=0 with 10 ticks -> time frozen. P_HOUR_MAX=12, set 11:59:59, 1 tick -> 00:00:00 with o_day_tick.
- Assert reset during S_LOAD -> all outputs 0 immediately (asynchronous); after release, one tick -> 00:00:01.
